// File: rtl/lm_head_argmax_if.sv
// Handshake/load bundle for lm_head_argmax; best_logit exists only with LM_HEAD_LOGIT_OUT_EN.
interface lm_head_argmax_if #(
  parameter int VOCAB_SIZE = 16,
  parameter int EMBED_DIM  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
);
  localparam int IDX_W = (VOCAB_SIZE > 1) ? $clog2(VOCAB_SIZE) : 1;
  localparam int DIM_W = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;

  logic                            load_en;
  logic [IDX_W-1:0]                load_token_idx;
  logic [DIM_W-1:0]                load_dim_idx;
  logic signed [DATA_WIDTH-1:0]    load_data;
  logic                            valid_in;
  logic [EMBED_DIM*DATA_WIDTH-1:0] hidden_in;
  logic                            ready_out;
  logic                            valid_out;
  logic [IDX_W-1:0]                token_id;
`ifdef LM_HEAD_LOGIT_OUT_EN
  logic signed [ACC_WIDTH-1:0]     best_logit;
`endif

  modport master (
    output load_en, load_token_idx, load_dim_idx, load_data, valid_in, hidden_in,
    input  ready_out, valid_out, token_id
`ifdef LM_HEAD_LOGIT_OUT_EN
    , input best_logit
`endif
  );

  modport slave (
    input  load_en, load_token_idx, load_dim_idx, load_data, valid_in, hidden_in,
    output ready_out, valid_out, token_id
`ifdef LM_HEAD_LOGIT_OUT_EN
    , output best_logit
`endif
  );
endinterface

// File: rtl/lm_head_argmax.sv
// Tied-embedding LM head: one MAC per cycle over every vocab row, returns the argmax token.
// Optional macro LM_HEAD_LOGIT_OUT_EN adds the registered best_logit output.
module lm_head_argmax #(
  parameter int VOCAB_SIZE = 16,
  parameter int EMBED_DIM  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic            clk,
  input  logic            rst,
  lm_head_argmax_if.slave bus
);
  localparam int IDX_W = (VOCAB_SIZE > 1) ? $clog2(VOCAB_SIZE) : 1;
  localparam int DIM_W = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;
  localparam int PW    = 2 * DATA_WIDTH;

  // Elements are Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS; the accumulator must hold EMBED_DIM full products.
  if (ACC_WIDTH < PW + DIM_W || FRAC_BITS >= DATA_WIDTH) begin : g_bad_cfg
    $error("lm_head_argmax: ACC_WIDTH too narrow or FRAC_BITS invalid");
  end

  // state  | meaning
  // S_IDLE | ready; accepts table writes and start requests
  // S_MAC  | accumulate hidden[d]*table[t][d], one dim per cycle
  // S_CMP  | compare row logit against running best, advance row
  // S_DONE | one-cycle result pulse
  typedef enum logic [1:0] {S_IDLE, S_MAC, S_CMP, S_DONE} state_t;

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] emb [VOCAB_SIZE][EMBED_DIM];
  logic signed [DATA_WIDTH-1:0] hidden_q [EMBED_DIM];
  logic [IDX_W-1:0]             t;
  logic [DIM_W-1:0]             d;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  best;
  logic [IDX_W-1:0]             best_idx;
  logic                         valid_q;
  logic [IDX_W-1:0]             token_q;
`ifdef LM_HEAD_LOGIT_OUT_EN
  logic signed [ACC_WIDTH-1:0]  logit_q;
`endif

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic                        take;
  logic                        load_ok;

  assign prod     = PW'(hidden_q[d]) * PW'(emb[t][d]);
  assign prod_ext = ACC_WIDTH'(prod);
  // Strict compare keeps the lowest index on ties; row 0 always seeds the best.
  assign take     = (t == '0) || (acc > best);
  assign load_ok  = (int'(bus.load_token_idx) < VOCAB_SIZE) &&
                    (int'(bus.load_dim_idx) < EMBED_DIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      t        <= '0;
      d        <= '0;
      acc      <= '0;
      best     <= '0;
      best_idx <= '0;
      valid_q  <= 1'b0;
      token_q  <= '0;
`ifdef LM_HEAD_LOGIT_OUT_EN
      logit_q  <= '0;
`endif
      for (int i = 0; i < VOCAB_SIZE; i++)
        for (int j = 0; j < EMBED_DIM; j++)
          emb[i][j] <= '0;
      for (int j = 0; j < EMBED_DIM; j++)
        hidden_q[j] <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.load_en && load_ok)
            emb[bus.load_token_idx][bus.load_dim_idx] <= bus.load_data;
          if (bus.valid_in) begin
            for (int j = 0; j < EMBED_DIM; j++)
              hidden_q[j] <= bus.hidden_in[j*DATA_WIDTH +: DATA_WIDTH];
            t     <= '0;
            d     <= '0;
            acc   <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          if (d == DIM_W'(EMBED_DIM - 1))
            state <= S_CMP;
          else
            d <= d + 1'b1;
        end
        S_CMP: begin
          if (take) begin
            best     <= acc;
            best_idx <= t;
          end
          if (t == IDX_W'(VOCAB_SIZE - 1)) begin
            // Result registers load here so they are valid during the DONE cycle.
            state   <= S_DONE;
            valid_q <= 1'b1;
            token_q <= take ? t : best_idx;
`ifdef LM_HEAD_LOGIT_OUT_EN
            logit_q <= take ? acc : best;
`endif
          end else begin
            t     <= t + 1'b1;
            d     <= '0;
            acc   <= '0;
            state <= S_MAC;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_out  = (state == S_IDLE);
  assign bus.valid_out  = valid_q;
  assign bus.token_id   = token_q;
`ifdef LM_HEAD_LOGIT_OUT_EN
  assign bus.best_logit = logit_q;
`endif
endmodule
